writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
// Write-back stage and architectural register file of the SEQ Y86-64 core; the write side of the register
// array that decode reads. Each committed instruction's icode, cnd, rA, rB, valE and valM select dstE/dstM.
// Registers update on the clock edge. The full array is driven to decode as a flat bus.
// Also holds the sticky halt state and a retired-instruction counter.
// PARAMETERS
// WIDTH    64      register width, bits
// NREG     15      architectural registers, indices 0..NREG-1; index 15 (4'hF) = "no register"
// SP_IDX   14      stack-pointer index (regArr[14] is %rsp in this core)
// SP_INIT  64'h0   %rsp value loaded at reset
// PORTS
// clk        in   1            clock; all state updates on posedge
// reset      in   1            synchronous, active-high
// wb_valid   in   1            1 = commit the instruction on the inputs this cycle
// icode      in   4            instruction code of the committing instruction
// cnd        in   1            condition result from execute (cmovxx qualifier)
// rA         in   4            rA field
// rB         in   4            rB field
// valE       in   WIDTH        ALU result
// valM       in   WIDTH        memory read data
// reg_flat   out  NREG*WIDTH   register array, reg i at [i*WIDTH +: WIDTH], registered
// halted     out  1            sticky; set when halt (icode 0) commits
// retired    out  64           count of committed instructions
// BEHAVIOUR
// Reset (reset=1 at posedge): all regs 0 except reg[SP_IDX]=SP_INIT; halted=0; retired=0. Reset wins over all.
// dstE (combinational, only when wb_valid=1; otherwise 4'hF):
// - icode 2: rB if cnd=1, else 4'hF.
// - icode 3 or 6: rB.
// - icode 8, 9, 10, 11: SP_IDX.
// - Else 4'hF.
// dstM: rA for icode 5 and 11; else 4'hF.
// Commit at posedge when wb_valid=1 and halted=0:
// - reg[dstE] <= valE, if dstE != 4'hF.
// - reg[dstM] <= valM, if dstM != 4'hF.
// - If dstE == dstM, valM wins (popq %rsp yields the popped value).
// - Index >= NREG other than 4'hF: no write.
// - retired <= retired+1; wraps modulo 2^64.
// Halt commit (icode 0, wb_valid=1, halted=0): no register write, retired increments, halted<=1.
// While halted=1: no register writes and retired frozen; only reset clears halted.
// icode 1, 4, 7 and codes > 11: no register write, retired increments.
// wb_valid=0: no state change.
// Latency: one cycle. A write at edge N appears on reg_flat after edge N; no same-cycle bypass to decode.
// Reset asserted mid-stream discards the commit presented in that cycle.
// TESTING
// - Reset: SP_INIT=64'h200, assert reset 1 cycle -> reg_flat all 0 except reg14=64'h200; retired=0; halted=0.
// - irmovq: icode=3, rB=2, valE=64'h1234 -> next cycle reg2=64'h1234, retired=1; cmov icode=2, cnd=0, rB=3 -> reg3 unchanged.
// - popq %rsp: icode=11, rA=14, valE=64'h208, valM=64'hDEAD -> reg14=64'hDEAD.
// - mrmovq + OPq: icode=5, rA=1, valM=64'h55 -> reg1=64'h55; next icode=6, rB=1, valE=64'h77 -> reg1=64'h77.
// - Halt: icode=0 -> halted=1; then icode=3, rB=0, valE=9 -> reg0 unchanged, retired frozen.
//   Reset -> halted=0.
// - No-op cases: wb_valid=0 with icode=3 -> no change; icode=3, rB=4'hF -> no write, retired still increments.

Source files
------------

// File: rtl/writeback_regfile.sv
// Write-back stage and architectural register file of the SEQ Y86-64 core.
// Also holds the sticky halt flag and the retired-instruction counter.
module writeback_regfile #(
    parameter int               WIDTH   = 64,
    parameter int               NREG    = 15,
    parameter int               SP_IDX  = 14,
    parameter logic [WIDTH-1:0] SP_INIT = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [3:0]            icode,
    input  logic                  cnd,
    input  logic [3:0]            rA,
    input  logic [3:0]            rB,
    input  logic [WIDTH-1:0]      valE,
    input  logic [WIDTH-1:0]      valM,
    output logic [NREG*WIDTH-1:0] reg_flat,
    output logic                  halted,
    output logic [63:0]           retired
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] SP    = 4'(SP_IDX);

    logic [WIDTH-1:0] regs [NREG];
    logic [3:0]       dste;
    logic [3:0]       dstm;
    logic             commit;

    assign commit = wb_valid && !halted;

    always_comb begin
        dste = RNONE;
        if (wb_valid) begin
            unique case (1'b1)
                (icode == 4'h2):
                    dste = cnd ? rB : RNONE;
                (icode == 4'h3),
                (icode == 4'h6):
                    dste = rB;
                (icode >= 4'h8 && icode <= 4'hB):
                    dste = SP;
                default:
                    dste = RNONE;
            endcase
        end
    end

    always_comb begin
        dstm = RNONE;
        if (wb_valid && (icode == 4'h5 || icode == 4'hB))
            dstm = rA;
    end

    // valM is checked first so popq %rsp keeps the popped value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            halted  <= 1'b0;
            retired <= '0;
        end else if (commit) begin
            retired <= retired + 64'd1;
            if (icode == 4'h0)
                halted <= 1'b1;
            for (int i = 0; i < NREG; i++) begin
                if (dstm == 4'(i))
                    regs[i] <= valM;
                else if (dste == 4'(i))
                    regs[i] <= valE;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign reg_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: directed commits with
// hand-written expected register state, checked by a separate monitor.
module tb_writeback_regfile;

    localparam int W = 64;
    localparam int N = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           wb_valid = 1'b0;
    logic [3:0]     icode = 4'h1;
    logic           cnd = 1'b0;
    logic [3:0]     rA = 4'hF;
    logic [3:0]     rB = 4'hF;
    logic [W-1:0]   valE = '0;
    logic [W-1:0]   valM = '0;
    logic [N*W-1:0] reg_flat;
    logic           halted;
    logic [63:0]    retired;

    writeback_regfile #(
        .WIDTH(W), .NREG(N), .SP_IDX(14), .SP_INIT(64'h200)
    ) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid),
        .icode(icode), .cnd(cnd), .rA(rA), .rB(rB),
        .valE(valE), .valM(valM), .reg_flat(reg_flat),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] flat;
        logic           h;
        logic [63:0]    r;
        string          name;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] er [N];
    logic         eh;
    logic [63:0]  eret;
    int           checks = 0;
    int           failures = 0;

    // monitor: one registered snapshot per issued cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (reg_flat !== e.flat) begin
                    failures++;
                    $display("FAIL %s regs: got %h want %h",
                             e.name, reg_flat, e.flat);
                end
                checks++;
                if (halted !== e.h) begin
                    failures++;
                    $display("FAIL %s halted: got %b want %b",
                             e.name, halted, e.h);
                end
                checks++;
                if (retired !== e.r) begin
                    failures++;
                    $display("FAIL %s retired: got %0d want %0d",
                             e.name, retired, e.r);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] ic,
                         input logic c, input logic [3:0] a,
                         input logic [3:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] m);
        @(negedge clk);
        reset = 1'b0;
        wb_valid = v; icode = ic; cnd = c;
        rA = a; rB = b; valE = e; valM = m;
    endtask

    task automatic issue(input string nm);
        exp_t x;
        for (int i = 0; i < N; i++)
            x.flat[i*W +: W] = er[i];
        x.h = eh;
        x.r = eret;
        x.name = nm;
        q.push_back(x);
        @(posedge clk);
    endtask

    task automatic exp_reset();
        for (int i = 0; i < N; i++)
            er[i] = '0;
        er[14] = 64'h200;
        eh = 1'b0;
        eret = '0;
    endtask

    initial begin
        drive(1'b0, 4'h1, 1'b0, 4'hF, 4'hF, '0, '0);
        reset = 1'b1;
        exp_reset();
        issue("reset");

        drive(1'b1, 4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, '0);
        er[2] = 64'h1234; eret = 1;
        issue("irmovq");

        drive(1'b1, 4'h2, 1'b0, 4'h4, 4'h3, 64'h99, '0);
        eret = 2;
        issue("cmov_nt");

        drive(1'b1, 4'h2, 1'b1, 4'h4, 4'h3, 64'h99, '0);
        er[3] = 64'h99; eret = 3;
        issue("cmov_t");

        drive(1'b1, 4'hB, 1'b0, 4'hE, 4'hF, 64'h208, 64'hDEAD);
        er[14] = 64'hDEAD; eret = 4;
        issue("popq_rsp");

        drive(1'b1, 4'h5, 1'b0, 4'h1, 4'h7, 64'h3333, 64'h55);
        er[1] = 64'h55; eret = 5;
        issue("mrmovq");

        drive(1'b1, 4'h6, 1'b0, 4'h2, 4'h1, 64'h77, 64'h1);
        er[1] = 64'h77; eret = 6;
        issue("opq");

        drive(1'b1, 4'hA, 1'b0, 4'h2, 4'hF, 64'h1F0, 64'h5);
        er[14] = 64'h1F0; eret = 7;
        issue("pushq");

        drive(1'b1, 4'h1, 1'b0, 4'h2, 4'h2, 64'h11, 64'h22);
        eret = 8;
        issue("nop");

        drive(1'b0, 4'h3, 1'b0, 4'hF, 4'h5, 64'h5, '0);
        issue("invalid");

        drive(1'b1, 4'h3, 1'b0, 4'hF, 4'hF, 64'h5, '0);
        eret = 9;
        issue("rb_none");

        drive(1'b1, 4'h4, 1'b0, 4'h2, 4'h2, 64'h44, 64'h45);
        eret = 10;
        issue("rmmovq");

        drive(1'b1, 4'hC, 1'b1, 4'h2, 4'h2, 64'h44, 64'h45);
        eret = 11;
        issue("icode_c");

        drive(1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 64'h66, 64'h67);
        eh = 1'b1; eret = 12;
        issue("halt");

        drive(1'b1, 4'h3, 1'b0, 4'hF, 4'h0, 64'h9, '0);
        issue("post_halt");

        drive(1'b1, 4'h3, 1'b0, 4'hF, 4'h5, 64'h77, '0);
        reset = 1'b1;
        exp_reset();
        issue("mid_reset");

        drive(1'b1, 4'h3, 1'b0, 4'hF, 4'h0, 64'h9, '0);
        er[0] = 64'h9; eret = 1;
        issue("after_reset");

        drive(1'b0, 4'h1, 1'b0, 4'hF, 4'hF, '0, '0);
        for (int k = 0; k < 5 && q.size() != 0; k++)
            @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
